// File: rtl/demux_sequencer_if.sv
// Handshake and demux-drive bundle for demux_sequencer.
// master: the upstream/observer side; slave: the sequencer itself.
interface demux_sequencer_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       i;
  logic [1:0] s;
  logic       out_valid;
  logic       frame_done;
  logic       busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, i, s, out_valid, frame_done, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, i, s, out_valid, frame_done, busy
  );
endinterface

// File: rtl/demux_sequencer.sv
// demux_sequencer: buffers 4-bit words in a 2-entry FIFO and serialises each
// word onto a 1:4 demux as (s, i) pairs in ascending channel order, one per
// cycle, with back-to-back words streaming without a bubble.
// Optional feature macro: SEQ_SKIP_ZERO_EN -- only channels whose bit is 1
// are visited; all-zero words are dropped without any transfer.
module demux_sequencer (
  input  logic              clk,
  input  logic              rst,
  demux_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state_reg, state_next;
  logic [1:0] ch_reg, ch_next;
  logic [3:0] word_reg, word_next;
  logic       i_reg, i_next;
  logic [1:0] s_reg, s_next;
  logic       out_valid_reg, out_valid_next;
  logic       frame_done_reg, frame_done_next;

  // FIFO storage and pointers
  logic [3:0] fifo_mem [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       push;
  logic       pop;
  logic       fifo_empty;
  logic [3:0] head;

  // Per-word sequencing helpers (differ between plain and skip-zero builds)
  logic       head_live;   // head word produces at least one transfer
  logic [1:0] first_ch;    // first channel of the head word
  logic       last_ch;     // current channel is the word's final transfer
  logic [1:0] step_ch;     // channel following the current one

  // Full means no push this cycle, even if a pop frees a slot concurrently.
  assign bus.in_ready = (count_reg != 2'd2);
  assign push         = bus.in_valid && bus.in_ready && !rst;
  assign fifo_empty   = (count_reg == 2'd0);
  assign head         = fifo_mem[rd_ptr_reg];

  assign bus.i          = i_reg;
  assign bus.s          = s_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.busy       = (state_reg == SEND) || !fifo_empty;

  // FIFO entry write: each slot captures in_data when the write pointer selects it
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_slot
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == 1'(gi))) begin
        fifo_mem[gi] <= bus.in_data;
      end
    end
  end

  // FIFO pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef SEQ_SKIP_ZERO_EN
  // Index of the lowest set bit; only meaningful for a non-zero argument.
  function automatic logic [1:0] lowest_set(input logic [3:0] w);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w[k]) r = 2'(k);
    end
    return r;
  endfunction

  logic [3:0] above_mask;
  logic [3:0] remaining;

  // Channels still to visit are the set bits strictly above the current one.
  assign above_mask = 4'b1110 << ch_reg;
  assign remaining  = word_reg & above_mask;
  assign head_live  = |head;
  assign first_ch   = lowest_set(head);
  assign last_ch    = ~|remaining;
  assign step_ch    = lowest_set(remaining);
`else
  assign head_live  = 1'b1;
  assign first_ch   = 2'd0;
  assign last_ch    = (ch_reg == 2'd3);
  assign step_ch    = ch_reg + 2'd1;
`endif

  // Next-state, pop decision and next registered demux outputs
  always_comb begin
    state_next      = state_reg;
    ch_next         = ch_reg;
    word_next       = word_reg;
    pop             = 1'b0;
    i_next          = 1'b0;
    s_next          = 2'b00;
    out_valid_next  = 1'b0;
    frame_done_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_live) begin
            word_next  = head;
            ch_next    = first_ch;
            state_next = SEND;
          end
        end
      end
      SEND: begin
        out_valid_next  = 1'b1;
        s_next          = ch_reg;
        i_next          = word_reg[ch_reg];
        frame_done_next = last_ch;
        if (!last_ch) begin
          ch_next = step_ch;
        end else if (!fifo_empty) begin
          // Chain straight into the next word so the stream has no gap.
          pop = 1'b1;
          if (head_live) begin
            word_next = head;
            ch_next   = first_ch;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM, word holding register and registered demux outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ch_reg         <= 2'd0;
      word_reg       <= 4'd0;
      i_reg          <= 1'b0;
      s_reg          <= 2'b00;
      out_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ch_reg         <= ch_next;
      word_reg       <= word_next;
      i_reg          <= i_next;
      s_reg          <= s_next;
      out_valid_reg  <= out_valid_next;
      frame_done_reg <= frame_done_next;
    end
  end

endmodule
